// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic: mux select
// encodings, FSM states and the hard-wired zero register.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_IMM   = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_MEMWAIT = 2'd2
    } state_e;

endpackage

// File: rtl/fwd_compare.sv
// Per-operand forwarding select: immediate, then EX/MEM, then MEM/WB, else the
// register file. A load sitting in MEM is never forwarded from EX/MEM.
module fwd_compare
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_wr_i,
    input  logic              mem_ld_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wr_i,
    input  logic              use_imm_i,
    output logic [1:0]        sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (use_imm_i) begin
            sel_o = FWD_IMM;
        end else if (mem_wr_i && !mem_ld_i && (mem_rd_i != REG_ZERO) && (mem_rd_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (wb_wr_i && (wb_rd_i != REG_ZERO) && (wb_rd_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Define HAZARD_STATS_EN to add saturating LDSTALL / MEMWAIT cycle counters.
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned STALL_CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_use_imm,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              mem_stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall_pc,
    output logic              bubble_id_ex,
    output logic              freeze
`ifdef HAZARD_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stat_ldstall,
    output logic [STALL_CNT_W-1:0] stat_memwait
`endif
);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] mem_rd_q, wb_rd_q;
    logic              mem_wr_q, mem_ld_q, wb_wr_q;
    logic              load_use;
    logic              freeze_c, stall_c, bubble_c;
    logic [1:0]        sel_a, sel_b;

    assign load_use = ex_memread && ex_regwrite && (ex_rd != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // The release cycle of MEMWAIT is already a running cycle, so it
    // re-evaluates load-use exactly like RUN.
    always_comb begin
        state_d  = state_q;
        freeze_c = mem_stall;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        unique case (state_q)
            S_RUN, S_MEMWAIT: begin
                if (mem_stall) begin
                    state_d = S_MEMWAIT;
                end else if (load_use) begin
                    state_d  = S_LDSTALL;
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LDSTALL: begin
                if (!mem_stall) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            mem_rd_q <= '0;
            mem_wr_q <= 1'b0;
            mem_ld_q <= 1'b0;
            wb_rd_q  <= '0;
            wb_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!freeze_c) begin
                mem_rd_q <= ex_rd;
                // While in LDSTALL the EX stage holds the inserted bubble.
                mem_wr_q <= (state_q == S_LDSTALL) ? 1'b0 : ex_regwrite;
                mem_ld_q <= (state_q == S_LDSTALL) ? 1'b0 : ex_memread;
                wb_rd_q  <= mem_rd_q;
                wb_wr_q  <= mem_wr_q;
            end
        end
    end

    fwd_compare #(.REG_AW(REG_AW)) u_fwd_a (
        .src_i     (ex_rs),
        .mem_rd_i  (mem_rd_q),
        .mem_wr_i  (mem_wr_q),
        .mem_ld_i  (mem_ld_q),
        .wb_rd_i   (wb_rd_q),
        .wb_wr_i   (wb_wr_q),
        .use_imm_i (1'b0),
        .sel_o     (sel_a)
    );

    fwd_compare #(.REG_AW(REG_AW)) u_fwd_b (
        .src_i     (ex_rt),
        .mem_rd_i  (mem_rd_q),
        .mem_wr_i  (mem_wr_q),
        .mem_ld_i  (mem_ld_q),
        .wb_rd_i   (wb_rd_q),
        .wb_wr_i   (wb_wr_q),
        .use_imm_i (ex_use_imm),
        .sel_o     (sel_b)
    );

    // Outputs are forced low for the whole time reset is asserted.
    assign fwd_sel_a    = rst_n ? sel_a : FWD_RF;
    assign fwd_sel_b    = rst_n ? sel_b : FWD_RF;
    assign stall_pc     = rst_n & stall_c;
    assign bubble_id_ex = rst_n & bubble_c;
    assign freeze       = rst_n & freeze_c;

`ifdef HAZARD_STATS_EN
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [STALL_CNT_W-1:0] ldstall_cnt_q, memwait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldstall_cnt_q <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if ((state_q == S_LDSTALL) && !(&ldstall_cnt_q)) ldstall_cnt_q <= ldstall_cnt_q + CNT_ONE;
            if (freeze_c && !(&memwait_cnt_q)) memwait_cnt_q <= memwait_cnt_q + CNT_ONE;
        end
    end

    assign stat_ldstall = ldstall_cnt_q;
    assign stat_memwait = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus
// randomized traffic against a stage-slot reference model.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
    logic       id_use_rs, id_use_rt, ex_use_imm, ex_regwrite, ex_memread, mem_stall;
    logic [1:0] fwd_sel_a, fwd_sel_b;
    logic       stall_pc, bubble_id_ex, freeze;
`ifdef HAZARD_STATS_EN
    logic [15:0] stat_ldstall, stat_memwait;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_use_imm   (ex_use_imm),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_stall    (mem_stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_pc     (stall_pc),
        .bubble_id_ex (bubble_id_ex),
        .freeze       (freeze)
`ifdef HAZARD_STATS_EN
        ,
        .stat_ldstall (stat_ldstall),
        .stat_memwait (stat_memwait)
`endif
    );

    // Reference model: the destinations of the instructions in MEM (slot 0)
    // and WB (slot 1), plus whether EX currently holds an inserted bubble.
    typedef struct {
        logic [4:0] rd;
        bit         wr;
        bit         ld;
    } slot_t;

    slot_t slots[2];
    bit    bubble_in_ex;

    function automatic logic [1:0] model_fwd(input logic [4:0] x);
        if (x == 5'd0) return 2'd0;
        for (int s = 0; s < 2; s++) begin
            if (slots[s].wr && !(s == 0 && slots[s].ld) && slots[s].rd == x) return 2'(s + 1);
        end
        return 2'd0;
    endfunction

    function automatic bit model_hazard();
        return ex_memread && ex_regwrite && ex_rd != 5'd0 &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_use_imm = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; mem_stall = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) slots[s] = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
        bubble_in_ex = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ex_use_imm = 1; mem_stall = 1; ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
        id_rt = 5; id_use_rt = 1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze} !== 7'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze});
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        ex_rs = 0; ex_rt = 0;
        #1;
        tests++;
        if ({fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze} !== 7'd0) begin
            fails++;
            $display("FAIL reset_release: got %b required 0000000",
                     {fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_rd = 3; ex_regwrite = 1; ex_rs = 1; ex_rt = 2;
        @(negedge clk);
        ex_rs = 3; ex_rd = 4; ex_regwrite = 1;
        #1;
        tests++;
        if (fwd_sel_a !== 2'b01) begin
            fails++; $display("FAIL b2b_exmem: fwd_sel_a=%b required 01", fwd_sel_a);
        end
        @(negedge clk);
        ex_rs = 3; ex_rt = 2; ex_rd = 0; ex_regwrite = 0;
        #1;
        tests++;
        if (fwd_sel_a !== 2'b10) begin
            fails++; $display("FAIL b2b_memwb: fwd_sel_a=%b required 10", fwd_sel_a);
        end
        tests++;
        if (fwd_sel_b !== 2'b00) begin
            fails++; $display("FAIL b2b_nomatch_b: fwd_sel_b=%b required 00", fwd_sel_b);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        do_reset();
        ex_rd = 0; ex_regwrite = 1;
        @(negedge clk);
        ex_rs = 0; ex_rd = 0; ex_regwrite = 1;
        #1;
        tests++;
        if (fwd_sel_a !== 2'b00) begin
            fails++; $display("FAIL zero_exmem: fwd_sel_a=%b required 00", fwd_sel_a);
        end
        @(negedge clk);
        ex_regwrite = 0;
        #1;
        tests++;
        if (fwd_sel_a !== 2'b00) begin
            fails++; $display("FAIL zero_memwb: fwd_sel_a=%b required 00", fwd_sel_a);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rt = 5; id_use_rt = 1;
        #1;
        tests++;
        if ({stall_pc, bubble_id_ex} !== 2'b11) begin
            fails++; $display("FAIL ldu_detect: stall/bubble=%b required 11", {stall_pc, bubble_id_ex});
        end
        @(negedge clk);
        // Bubble in EX; ex_rt aimed at the load in MEM must not forward from EX/MEM.
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_rt = 5;
        #1;
        tests++;
        if ({stall_pc, bubble_id_ex} !== 2'b00) begin
            fails++; $display("FAIL ldu_one_cycle: stall/bubble=%b required 00", {stall_pc, bubble_id_ex});
        end
        tests++;
        if (fwd_sel_b !== 2'b00) begin
            fails++; $display("FAIL ldu_load_in_mem: fwd_sel_b=%b required 00", fwd_sel_b);
        end
        @(negedge clk);
        id_use_rt = 0; ex_rt = 5; ex_rd = 6; ex_regwrite = 1;
        #1;
        tests++;
        if ({fwd_sel_b, stall_pc} !== 3'b100) begin
            fails++; $display("FAIL ldu_fwd_wb: sel_b,stall=%b required 100", {fwd_sel_b, stall_pc});
        end
        @(negedge clk);
    endtask

    task automatic test_imm_priority();
        do_reset();
        ex_rd = 7; ex_regwrite = 1;
        @(negedge clk);
        ex_rs = 7; ex_rt = 7; ex_use_imm = 1; ex_regwrite = 0;
        #1;
        tests++;
        if (fwd_sel_b !== 2'b11) begin
            fails++; $display("FAIL imm_priority: fwd_sel_b=%b required 11", fwd_sel_b);
        end
        tests++;
        if (fwd_sel_a !== 2'b01) begin
            fails++; $display("FAIL imm_other_operand: fwd_sel_a=%b required 01", fwd_sel_a);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_stall();
        do_reset();
        ex_rd = 9; ex_regwrite = 1;
        @(negedge clk);
        ex_rs = 9; ex_rd = 10; ex_regwrite = 0; mem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if ({freeze, fwd_sel_a} !== 3'b101) begin
                fails++; $display("FAIL stall_hold[%0d]: freeze,sel_a=%b required 101", i, {freeze, fwd_sel_a});
            end
            @(negedge clk);
        end
        mem_stall = 0;
        #1;
        tests++;
        if ({freeze, fwd_sel_a} !== 3'b001) begin
            fails++; $display("FAIL stall_release: freeze,sel_a=%b required 001", {freeze, fwd_sel_a});
        end
        @(negedge clk);
        #1;
        tests++;
        if (fwd_sel_a !== 2'b10) begin
            fails++; $display("FAIL stall_resume: fwd_sel_a=%b required 10", fwd_sel_a);
        end
`ifdef HAZARD_STATS_EN
        tests++;
        if (stat_memwait !== 16'd4) begin
            fails++; $display("FAIL stat_memwait: got %0d required 4", stat_memwait);
        end
`endif
        @(negedge clk);
        // Load-use arriving together with a D-cache stall: the stall wins.
        clear_inputs();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rs = 5; id_use_rs = 1; mem_stall = 1;
        #1;
        tests++;
        if ({freeze, stall_pc, bubble_id_ex} !== 3'b100) begin
            fails++; $display("FAIL stall_vs_ldu: frz,stall,bub=%b required 100", {freeze, stall_pc, bubble_id_ex});
        end
        @(negedge clk);
        mem_stall = 0;
        #1;
        tests++;
        if ({freeze, stall_pc, bubble_id_ex} !== 3'b011) begin
            fails++; $display("FAIL ldu_after_stall: frz,stall,bub=%b required 011", {freeze, stall_pc, bubble_id_ex});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rt = 5; id_use_rt = 1;
        @(negedge clk);
        ex_use_imm = 1; mem_stall = 1;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze} !== 7'd0) begin
            fails++;
            $display("FAIL reset_in_ldstall: got %b required 0000000",
                     {fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rt = 5; id_use_rt = 1;
        #1;
        tests++;
        if ({stall_pc, bubble_id_ex} !== 2'b11) begin
            fails++; $display("FAIL run_after_reset: stall/bubble=%b required 11", {stall_pc, bubble_id_ex});
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] exp_a, exp_b;
        bit         exp_stall, exp_frz, hz;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            ex_rs       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_use_imm  = ($urandom_range(0, 3) == 0);
            ex_regwrite = ($urandom_range(0, 3) != 0);
            ex_memread  = ($urandom_range(0, 2) == 0);
            mem_stall   = ($urandom_range(0, 5) == 0);

            hz        = model_hazard();
            exp_a     = model_fwd(ex_rs);
            exp_b     = ex_use_imm ? 2'b11 : model_fwd(ex_rt);
            exp_frz   = mem_stall;
            exp_stall = !mem_stall && !bubble_in_ex && hz;
            #1;
            tests++;
            if ({fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze} !==
                {exp_a, exp_b, exp_stall, exp_stall, exp_frz}) begin
                fails++;
                $display("FAIL random[%0d]: a,b,stall,bub,frz=%b required %b", n,
                         {fwd_sel_a, fwd_sel_b, stall_pc, bubble_id_ex, freeze},
                         {exp_a, exp_b, exp_stall, exp_stall, exp_frz});
            end
            if (slots[0].wr && slots[0].ld && ex_rs != 5'd0 && ex_rs == slots[0].rd) begin
                tests++;
                if (fwd_sel_a === 2'b01) begin
                    fails++; $display("FAIL random_load_in_mem[%0d]: fwd_sel_a=01 required not 01", n);
                end
            end
            if (!mem_stall) begin
                slots[1] = slots[0];
                slots[0] = '{rd: ex_rd, wr: bubble_in_ex ? 1'b0 : ex_regwrite,
                             ld: bubble_in_ex ? 1'b0 : ex_memread};
                bubble_in_ex = exp_stall;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_back_to_back();
        test_zero_reg();
        test_load_use();
        test_imm_priority();
        test_mem_stall();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipelined MIPS core.
- Shadows destination-register info of instructions in the MEM and WB stages.
- Drives the 2-bit select inputs of the two 32-bit 4:1 ALU operand muxes in EX.
- Detects load-use hazards and handles D-cache stalls. It emits stall and bubble controls to the IF/ID and ID/EX pipeline registers.

Parameters:
- REG_AW, 5, register-address width.
- STALL_CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_AW  rs of the instruction in ID.
- id_rt  in  REG_AW  rt of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_rs  in  REG_AW  rs of the instruction in EX.
- ex_rt  in  REG_AW  rt of the instruction in EX.
- ex_use_imm  in  1  EX operand B is the immediate.
- ex_rd  in  REG_AW  destination of the instruction in EX.
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- mem_stall  in  1  D-cache busy; the whole pipeline freezes.
- fwd_sel_a  out  2  operand A mux select.
- fwd_sel_b  out  2  operand B mux select.
- stall_pc  out  1  hold PC and IF/ID.
- bubble_id_ex  out  1  load NOP into ID/EX.
- freeze  out  1  hold all pipeline registers.

Behaviour:
- Select encoding (matches mux inputs):
  - 00: register-file value.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB writeback data.
  - 11: immediate (operand B only).
- Internal shadow registers: mem_rd, mem_wr, mem_ld, wb_rd, wb_wr.
- Reset (async, rst_n=0): all shadow registers 0, FSM to RUN, all outputs 0.
- Shadow advance, on clk edge when not freeze:
  - mem_* <= ex_* when no bubble is in EX; otherwise mem_wr/mem_ld <= 0.
  - wb_* <= mem_*.
- Forwarding is combinational from shadow registers and ex_* inputs (0-cycle latency). For operand X in {rs, rt}:
  - 01 if mem_wr && !mem_ld && mem_rd!=0 && mem_rd==X.
  - else 10 if wb_wr && wb_rd!=0 && wb_rd==X.
  - else 00.
  - EX/MEM has priority over MEM/WB.
  - fwd_sel_b = 11 whenever ex_use_imm=1, regardless of matches.
  - Register $0 never forwards.
- Load-use: hazard when ex_memread && ex_regwrite && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
- FSM states: RUN, LDSTALL, MEMWAIT.
  - RUN:
    - mem_stall=1 -> MEMWAIT; freeze=1 in the same cycle (combinational).
    - else load-use -> LDSTALL; stall_pc=1 and bubble_id_ex=1 in the detecting cycle.
  - LDSTALL: exactly one cycle. The bubble advances and the load moves to MEM. Return to RUN. The load result is then forwarded from WB (sel 10) on the following EX cycle.
  - MEMWAIT: freeze=1 while mem_stall=1. Shadow registers and selects hold. mem_stall=0 -> RUN.
- Simultaneous mem_stall and load-use: mem_stall wins. Load-use is re-evaluated after the freeze.
- A load in MEM with a match never yields sel 01. This case is unreachable given the stall rule; the bench asserts it.
- Reset mid-stall: immediate return to RUN, outputs 0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds outputs stat_ldstall and stat_memwait, each STALL_CNT_W wide.
  - Saturating counters of LDSTALL cycles and MEMWAIT cycles.
  - Cleared by rst_n.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Localparams FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_IMM=2'b11.
  - FSM state encodings S_RUN, S_LDSTALL, S_MEMWAIT.
  - REG_ZERO=5'd0.
- One natural sub-module: fwd_compare. It does the per-operand priority compare and is instantiated twice (A and B).

Test Plan:
- Back-to-back ALU dependency: add $3 written, next instruction reads ex_rs=3 -> fwd_sel_a=01 in the same cycle; one cycle later, a third instruction reading $3 -> fwd_sel_a=10.
- Write to $0 by the prior instruction, ex_rs=0 -> fwd_sel_a=00.
- Load-use: EX lw $5, ID reads id_rt=5 -> stall_pc=1 and bubble_id_ex=1 for exactly one cycle; the next EX cycle gives fwd_sel_b=10.
- Immediate priority: ex_use_imm=1 with ex_rt matching mem_rd -> fwd_sel_b=11.
- mem_stall held 4 cycles during a dependency -> freeze=1 for 4 cycles; the sel value holds; resumes matching after release. With HAZARD_STATS_EN, stat_memwait=4.
- rst_n asserted in LDSTALL -> all outputs 0 asynchronously; FSM in RUN after release.
